// File: rtl/arr_dump_uart_pkg.sv
// Shared constants for the ARR snapshot UART dumper: frame layout, sequencer
// state encoding and the bit-timer width helper.
package arr_dump_uart_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam int         DATA_BYTES  = 40;
    localparam int         FRAME_BYTES = 42;
    localparam logic [5:0] LAST_IDX    = 6'(DATA_BYTES - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // CLKS_PER_BIT is at least 2, so $clog2 never returns zero here.
    function automatic int cnt_width(input int clks);
        return $clog2(clks);
    endfunction

endpackage

// File: rtl/arr_dump_uart_tx_byte.sv
// 8N1 byte serializer: a load strobe starts a 10-bit frame, byte_done marks the
// final cycle of the stop bit so the next load can follow with no gap.
module uart_tx_byte
    import arr_dump_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);
    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;
    logic             active;

    assign byte_done = active && (cnt == LAST_CNT) && (bit_idx == 4'd9);

    // shreg holds the bits still to be sent after the one currently on tx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            active  <= 1'b0;
        end else if (load) begin
            tx      <= 1'b0;
            shreg   <= {1'b1, data};
            cnt     <= '0;
            bit_idx <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (cnt == LAST_CNT) begin
                cnt   <= '0;
                tx    <= shreg[0];
                shreg <= {1'b1, shreg[8:1]};
                if (bit_idx == 4'd9) active  <= 1'b0;
                else                 bit_idx <= bit_idx + 4'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arr_dump_uart.sv
// Snapshots ARR0..ARR9 on START and streams header, 40 little-endian data
// bytes and an 8-bit checksum as one back-to-back 8N1 frame.
module arr_dump_uart
    import arr_dump_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] ARR0,
    input  logic [31:0] ARR1,
    input  logic [31:0] ARR2,
    input  logic [31:0] ARR3,
    input  logic [31:0] ARR4,
    input  logic [31:0] ARR5,
    input  logic [31:0] ARR6,
    input  logic [31:0] ARR7,
    input  logic [31:0] ARR8,
    input  logic [31:0] ARR9,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE
);
    logic [2:0]   state;
    logic [319:0] snap;
    logic [5:0]   idx;
    logic [7:0]   csum;
    logic         kick;
    logic         load;
    logic         byte_done;
    logic [7:0]   tx_byte;
    logic [5:0]   idx_nx;
    logic [7:0]   cur_byte;

    assign idx_nx   = idx + 6'd1;
    assign cur_byte = snap[{idx, 3'b000} +: 8];

    // The next byte is chosen on the stop-bit's last cycle so it loads with no gap.
    always_comb begin
        load    = 1'b0;
        tx_byte = HDR_BYTE;
        if (kick) begin
            load = 1'b1;
        end else if (byte_done) begin
            case (state)
                ST_HDR: begin
                    load    = 1'b1;
                    tx_byte = snap[7:0];
                end
                ST_DATA: begin
                    load    = 1'b1;
                    tx_byte = (idx == LAST_IDX) ? csum + cur_byte
                                                : snap[{idx_nx, 3'b000} +: 8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            snap  <= '0;
            idx   <= '0;
            csum  <= '0;
            kick  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            kick <= 1'b0;
            DONE <= 1'b0;
            case (state)
                ST_IDLE: if (START) begin
                    snap  <= {ARR9, ARR8, ARR7, ARR6, ARR5, ARR4, ARR3, ARR2, ARR1, ARR0};
                    csum  <= '0;
                    idx   <= '0;
                    kick  <= 1'b1;
                    state <= ST_HDR;
                end
                ST_HDR: begin
                    if (kick) BUSY <= 1'b1;
                    if (byte_done) begin
                        idx   <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: if (byte_done) begin
                    csum <= csum + cur_byte;
                    if (idx == LAST_IDX) state <= ST_CSUM;
                    else                 idx   <= idx_nx;
                end
                ST_CSUM: if (byte_done) begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= ST_FIN;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (load),
        .data      (tx_byte),
        .tx        (TX),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_arr_dump_uart.sv
// Directed bench for arr_dump_uart at CLKS_PER_BIT=4: decodes each frame from
// per-cycle TX samples and compares against hand-derived byte streams.
module tb_arr_dump_uart;
    import arr_dump_uart_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = FRAME_BYTES * 10 * CPB;

    typedef struct {
        string             name;
        logic [9:0][31:0]  arr;
        logic [7:0]        csum;
    } vec_t;
    typedef logic [7:0] frame_t [FRAME_BYTES];

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [9:0][31:0] arr;
    logic             TX, BUSY, DONE;

    int     errors = 0;
    int     checks = 0;
    vec_t   vecs [5];
    frame_t f, f2;
    int     lat;
    bit     stay_ok;

    always #5 CLK = ~CLK;

    arr_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .ARR0(arr[0]), .ARR1(arr[1]), .ARR2(arr[2]), .ARR3(arr[3]), .ARR4(arr[4]),
        .ARR5(arr[5]), .ARR6(arr[6]), .ARR7(arr[7]), .ARR8(arr[8]), .ARR9(arr[9]),
        .TX(TX), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic make_frame(input vec_t v, output frame_t fr);
        fr[0] = HDR_BYTE;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 4; j++)
                fr[1 + 4*i + j] = v.arr[i][8*j +: 8];
        fr[FRAME_BYTES-1] = v.csum;
    endtask

    task automatic launch(input logic [9:0][31:0] a);
        @(negedge CLK);
        arr   = a;
        START = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Waits (bounded) for the header start bit, samples the whole frame, then decodes it.
    task automatic receive(input frame_t exp, input string tag, input bit hold,
                           input int pulse, output int lt);
        bit         samp [FRAME_CYC];
        bit         busy_ok, done_ok, frm_ok, v;
        logic [7:0] got;
        lt = 0;
        do begin
            @(negedge CLK); @(posedge CLK); #1;
            lt++;
        end while (TX !== 1'b0 && lt < 40);
        chk(TX === 1'b0, {tag, "_start"}, TX, 0);
        if (TX !== 1'b0) return;
        samp[0] = 1'b0;
        busy_ok = (BUSY === 1'b1);
        done_ok = (DONE === 1'b0);
        for (int k = 1; k < FRAME_CYC; k++) begin
            @(negedge CLK);
            if (k == 1 && !hold) START = 1'b0;
            if (pulse > 0 && k == pulse) START = 1'b1;
            if (pulse > 0 && k == pulse + 2) START = 1'b0;
            @(posedge CLK); #1;
            samp[k] = TX;
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            if (DONE !== 1'b0) done_ok = 1'b0;
        end
        chk(busy_ok, {tag, "_busy_during"}, busy_ok, 1);
        chk(done_ok, {tag, "_done_early"}, done_ok, 1);
        @(negedge CLK); @(posedge CLK); #1;
        chk(DONE === 1'b1 && BUSY === 1'b0 && TX === 1'b1, {tag, "_fin_done_busy_tx"},
            {29'd0, DONE, BUSY, TX}, 32'h5);
        @(negedge CLK); @(posedge CLK); #1;
        chk(DONE === 1'b0, {tag, "_done_width"}, DONE, 0);
        for (int b = 0; b < FRAME_BYTES; b++) begin
            got    = '0;
            frm_ok = 1'b1;
            for (int j = 0; j < 10; j++) begin
                v = samp[b*10*CPB + j*CPB];
                for (int c = 1; c < CPB; c++)
                    if (samp[b*10*CPB + j*CPB + c] != v) frm_ok = 1'b0;
                if (j == 0 && v != 1'b0) frm_ok = 1'b0;
                else if (j == 9 && v != 1'b1) frm_ok = 1'b0;
                else if (j > 0 && j < 9) got[j-1] = v;
            end
            checks++;
            if (!frm_ok || got !== exp[b]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %02h (framing ok=%0d), expected %02h",
                         tag, b, got, frm_ok, exp[b]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].name = "v_seq";  vecs[0].arr = '0; vecs[0].arr[0] = 32'h04030201; vecs[0].csum = 8'h0A;
        vecs[1].name = "v_ones"; vecs[1].arr = {10{32'hFFFFFFFF}};                 vecs[1].csum = 8'hD8;
        vecs[2].name = "v_01";   vecs[2].arr = {10{32'h01010101}};                 vecs[2].csum = 8'h28;
        vecs[3].name = "v_wrap"; vecs[3].arr = '0; vecs[3].arr[0] = 32'h80808080;
                                 vecs[3].arr[1] = 32'h80808080;                    vecs[3].csum = 8'h00;
        vecs[4].name = "v_last"; vecs[4].arr = '0; vecs[4].arr[9] = 32'hDEADBEEF; vecs[4].csum = 8'h38;

        RST = 1'b0; START = 1'b0; arr = '0;
        repeat (2) @(posedge CLK); #1;
        chk(TX === 1'b1,   "reset_tx",   TX,   1);
        chk(BUSY === 1'b0, "reset_busy", BUSY, 0);
        chk(DONE === 1'b0, "reset_done", DONE, 0);
        @(negedge CLK); RST = 1'b1;
        repeat (3) @(posedge CLK); #1;
        chk(TX === 1'b1 && BUSY === 1'b0, "idle_after_reset", {TX, BUSY}, 2'b10);

        for (int i = 0; i < 5; i++) begin
            make_frame(vecs[i], f);
            launch(vecs[i].arr);
            receive(f, vecs[i].name, 1'b0, 0, lat);
            chk(lat == 1, {vecs[i].name, "_start_latency"}, lat, 1);
            repeat (3) @(posedge CLK);
        end

        // Inputs change right after capture: frame must carry the snapshot.
        make_frame(vecs[0], f);
        launch(vecs[0].arr);
        arr = {10{32'h12345678}};
        receive(f, "arr_change", 1'b0, 0, lat);
        repeat (3) @(posedge CLK);

        // A second START mid-frame must be ignored entirely.
        make_frame(vecs[2], f);
        launch(vecs[2].arr);
        receive(f, "mid_start", 1'b0, 600, lat);
        stay_ok = 1'b1;
        repeat (40) begin
            @(posedge CLK); #1;
            if (TX !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0) stay_ok = 1'b0;
        end
        chk(stay_ok, "mid_start_no_second_frame", stay_ok, 1);

        // Asynchronous reset while the start bit of byte 10 is on the line.
        launch(vecs[1].arr);
        START = 1'b0;
        repeat (402) @(posedge CLK); #1;
        chk(BUSY === 1'b1 && TX === 1'b0, "pre_reset_mid_byte", {BUSY, TX}, 2'b10);
        @(negedge CLK); RST = 1'b0; #1;
        chk(TX === 1'b1,   "async_reset_tx",   TX,   1);
        chk(BUSY === 1'b0, "async_reset_busy", BUSY, 0);
        chk(DONE === 1'b0, "async_reset_done", DONE, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        repeat (5) @(posedge CLK); #1;
        chk(TX === 1'b1 && BUSY === 1'b0, "idle_after_mid_reset", {TX, BUSY}, 2'b10);
        make_frame(vecs[4], f);
        launch(vecs[4].arr);
        receive(f, "after_reset", 1'b0, 0, lat);
        chk(lat == 1, "after_reset_latency", lat, 1);
        repeat (3) @(posedge CLK);

        // START held high across two frames; second one captures the new inputs.
        make_frame(vecs[3], f);
        make_frame(vecs[4], f2);
        launch(vecs[3].arr);
        receive(f, "hold1", 1'b1, 0, lat);
        chk(lat == 1, "hold1_latency", lat, 1);
        arr = vecs[4].arr;
        receive(f2, "hold2", 1'b0, 0, lat);
        chk(lat >= 2, "hold2_idle_gap", lat, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
